// File: rtl/mbist_mem_responder.sv
// Memory-under-test responder for the MBIST March C flow: registered-read array
// with capacity/width modelling and an optional fault table (MBIST_MEM_FAULT_INJ_EN).
module mbist_mem_responder #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned NUM_FAULTS = 4,
  localparam int unsigned SLOT_W = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            memtype,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  write_read,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  init_req,
  output logic                  busy,
  output logic                  oor_err,
  output logic                  cap_err,
  input  logic                  flt_load,
  input  logic                  flt_clear,
  input  logic [SLOT_W-1:0]     flt_slot,
  input  logic [ADDR_WIDTH-1:0] flt_addr,
  input  logic [5:0]            flt_bit,
  input  logic [1:0]            flt_type,
  output logic                  flt_ready
);

  localparam int unsigned DEPTH     = 1 << DEPTH_LOG2;
  localparam int unsigned BASE_BITS = 9;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state, state_next;
  logic [DEPTH_LOG2-1:0]   ptr, ptr_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rdata_next;
  logic                    oor_next;
  logic                    mem_we;
  logic [DEPTH_LOG2-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]   mem_wdata;

  int unsigned             n_bits;
  int unsigned             idx_bits;
  int unsigned             width;
  logic [ADDR_WIDTH-1:0]   hi_mask;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;
  logic [DATA_WIDTH-1:0]   wmask;
  logic [DATA_WIDTH-1:0]   cur_word;
  logic [DATA_WIDTH-1:0]   store_word;
  logic [DATA_WIDTH-1:0]   read_word;

  // Per-bit fault effects for the current address (one-hot per bit across types).
  logic [DATA_WIDTH-1:0]   f_sa0, f_sa1, f_tf, f_inv;

  // Capacity/width decode; index bits above the physical depth alias when cap_err is set.
  always_comb begin
    n_bits   = BASE_BITS + 32'(memtype[4:2]);
    idx_bits = (n_bits < DEPTH_LOG2) ? n_bits : DEPTH_LOG2;
    width    = 32'd8 << memtype[1:0];
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      hi_mask[i] = (i >= int'(n_bits));
    end
    in_range = ((address & hi_mask) == hi_mask);
    for (int i = 0; i < DEPTH_LOG2; i++) begin
      idx[i] = address[i] & (i < int'(idx_bits));
    end
    for (int i = 0; i < DATA_WIDTH; i++) begin
      wmask[i] = (i < int'(width));
    end
  end

  assign cap_err  = (n_bits > DEPTH_LOG2);
  assign cur_word = mem[idx];

`ifdef MBIST_MEM_FAULT_INJ_EN
  logic [NUM_FAULTS-1:0]   f_valid;
  logic [ADDR_WIDTH-1:0]   f_addr [NUM_FAULTS];
  logic [5:0]              f_bit  [NUM_FAULTS];
  logic [1:0]              f_type [NUM_FAULTS];
  logic                    load_ok;

  assign load_ok = flt_load && flt_ready && !flt_clear && (32'(flt_slot) < NUM_FAULTS);

  always_ff @(posedge clk) begin
    if (rst) begin
      f_valid   <= '0;
      flt_ready <= 1'b0;
    end else begin
      flt_ready <= (state_next == READY);
      if (flt_clear) begin
        f_valid <= '0;
      end else if (load_ok) begin
        f_valid[flt_slot] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (load_ok) begin
      f_addr[flt_slot] <= flt_addr;
      f_bit[flt_slot]  <= flt_bit;
      f_type[flt_slot] <= flt_type;
    end
  end

  // Walk slots high to low so the lowest matching slot is the last writer of a bit.
  always_comb begin
    f_sa0 = '0;
    f_sa1 = '0;
    f_tf  = '0;
    f_inv = '0;
    for (int s = NUM_FAULTS - 1; s >= 0; s--) begin
      if (f_valid[s] && (f_addr[s] == address)) begin
        for (int b = 0; b < DATA_WIDTH; b++) begin
          if (int'(f_bit[s]) == b) begin
            f_sa0[b] = (f_type[s] == 2'b00);
            f_sa1[b] = (f_type[s] == 2'b01);
            f_tf[b]  = (f_type[s] == 2'b10);
            f_inv[b] = (f_type[s] == 2'b11);
          end
        end
      end
    end
  end
`else
  logic unused_flt;

  assign unused_flt = ^{flt_load, flt_clear, flt_slot, flt_addr, flt_bit, flt_type};
  assign flt_ready  = 1'b0;
  assign f_sa0      = '0;
  assign f_sa1      = '0;
  assign f_tf       = '0;
  assign f_inv      = '0;
`endif

  // A TF-up cell that currently holds 0 cannot be written to 1.
  assign store_word = (wdata & wmask) & ~(f_tf & ~cur_word);
  assign read_word  = (((cur_word & ~f_sa0) | f_sa1) ^ f_inv) & wmask;

  // Next-state, array write port and output data.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    rdata_next = rdata;
    oor_next   = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = ptr;
    mem_wdata  = '0;
    case (state)
      INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr;
        mem_wdata = '0;
        if (init_req) begin
          ptr_next = '0;
        end else if (&ptr) begin
          state_next = READY;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr + DEPTH_LOG2'(1);
        end
      end
      READY: begin
        if (init_req) begin
          state_next = INIT;
          ptr_next   = '0;
        end
        if (!in_range) begin
          rdata_next = '0;
          oor_next   = 1'b1;
        end else if (write_read) begin
          mem_we    = 1'b1;
          mem_waddr = idx;
          mem_wdata = store_word;
        end else begin
          rdata_next = read_word;
        end
      end
      default: begin
        state_next = INIT;
        ptr_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT;
      ptr     <= '0;
      rdata   <= '0;
      busy    <= 1'b1;
      oor_err <= 1'b0;
    end else begin
      state   <= state_next;
      ptr     <= ptr_next;
      rdata   <= rdata_next;
      busy    <= (state_next == INIT);
      oor_err <= oor_next;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_mbist_mem_responder.sv
// Scoreboard bench for mbist_mem_responder: directed March-style sequences plus
// randomized traffic checked against a word-array / fault-list reference model.
module tb_mbist_mem_responder;

  localparam int DW = 64;
  localparam int AW = 16;
  localparam int DL = 10;
  localparam int NF = 4;
  localparam int SW = 2;
`ifdef MBIST_MEM_FAULT_INJ_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    memtype;
  logic [AW-1:0] address;
  logic          write_read;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          init_req;
  logic          busy;
  logic          oor_err;
  logic          cap_err;
  logic          flt_load;
  logic          flt_clear;
  logic [SW-1:0] flt_slot;
  logic [AW-1:0] flt_addr;
  logic [5:0]    flt_bit;
  logic [1:0]    flt_type;
  logic          flt_ready;

  mbist_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH_LOG2(DL), .NUM_FAULTS(NF)
  ) dut (
    .clk(clk), .rst(rst), .memtype(memtype), .address(address),
    .write_read(write_read), .wdata(wdata), .rdata(rdata), .init_req(init_req),
    .busy(busy), .oor_err(oor_err), .cap_err(cap_err), .flt_load(flt_load),
    .flt_clear(flt_clear), .flt_slot(flt_slot), .flt_addr(flt_addr),
    .flt_bit(flt_bit), .flt_type(flt_type), .flt_ready(flt_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] rdata;
    bit          oor;
    bit          busy;
    bit          fready;
    bit          cap;
  } exp_t;

  typedef struct {
    bit          v;
    logic [15:0] a;
    int          b;
    int          t;
  } flt_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model state
  bit          m_init;
  int          m_cnt;
  logic [63:0] m_rd;
  bit          m_oor;
  logic [63:0] mm [1024];
  flt_t        ft [NF];

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic int win_slot(input logic [15:0] a, input int b);
    for (int s = 0; s < NF; s++)
      if (ft[s].v && ft[s].a == a && ft[s].b == b) return s;
    return -1;
  endfunction

  function automatic void zero_mem();
    for (int i = 0; i < 1024; i++) mm[i] = 64'd0;
  endfunction

  // Computes the outputs expected after the coming rising edge from the current inputs.
  task automatic model_step();
    exp_t        e;
    int          n, w, idx, s;
    bit          valid;
    logic [63:0] wm, nw, d;
    if (rst) begin
      m_init = 1'b1;
      m_cnt  = 0;
      m_rd   = 64'd0;
      m_oor  = 1'b0;
      for (int i = 0; i < NF; i++) ft[i].v = 1'b0;
      zero_mem();
    end else begin
      m_oor = 1'b0;
      if (!m_init) begin
        n     = 9 + int'(memtype[4:2]);
        valid = ((int'(address) >> n) == ((1 << (16 - n)) - 1));
        idx   = int'(address) % (1 << ((n < DL) ? n : DL));
        w     = 8 << memtype[1:0];
        wm    = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (!valid) begin
          m_rd  = 64'd0;
          m_oor = 1'b1;
        end else if (write_read) begin
          nw = wdata & wm;
          for (int b = 0; b < w; b++) begin
            s = win_slot(address, b);
            if (s >= 0 && ft[s].t == 2 && mm[idx][b] == 1'b0 && nw[b]) nw[b] = 1'b0;
          end
          mm[idx] = nw;
        end else begin
          d = mm[idx];
          for (int b = 0; b < 64; b++) begin
            s = win_slot(address, b);
            if (s >= 0) begin
              case (ft[s].t)
                0: d[b] = 1'b0;
                1: d[b] = 1'b1;
                3: d[b] = ~d[b];
                default: ;
              endcase
            end
          end
          m_rd = d & wm;
        end
      end
      if (FI) begin
        if (flt_clear) begin
          for (int i = 0; i < NF; i++) ft[i].v = 1'b0;
        end else if (flt_load && !m_init) begin
          ft[flt_slot].v = 1'b1;
          ft[flt_slot].a = flt_addr;
          ft[flt_slot].b = int'(flt_bit);
          ft[flt_slot].t = int'(flt_type);
        end
      end
      if (m_init) begin
        if (init_req) m_cnt = 0;
        else begin
          m_cnt++;
          if (m_cnt == 1024) m_init = 1'b0;
        end
      end else if (init_req) begin
        m_init = 1'b1;
        m_cnt  = 0;
        zero_mem();
      end
    end
    e.rdata  = m_rd;
    e.oor    = m_oor;
    e.busy   = m_init;
    e.fready = FI && !m_init;
    e.cap    = ((9 + int'(memtype[4:2])) > DL);
    q.push_back(e);
  endtask

  task automatic drive(input bit wr, input logic [15:0] a, input logic [63:0] d);
    write_read = wr;
    address    = a;
    wdata      = d;
    model_step();
    @(negedge clk);
    init_req  = 1'b0;
    flt_load  = 1'b0;
    flt_clear = 1'b0;
  endtask

  task automatic load(input int slot, input logic [15:0] a, input int b, input int t);
    flt_load = 1'b1;
    flt_slot = SW'(slot);
    flt_addr = a;
    flt_bit  = 6'(b);
    flt_type = 2'(t);
    drive(1'b0, 16'hFFFF, 64'd0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 1200 && m_init; i++) drive(1'b0, 16'hFFFF, 64'd0);
  endtask

  // Monitor: compares every presented output against the queued expectation.
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("rdata", rdata, mon_e.rdata);
      chk("oor_err", 64'(oor_err), 64'(mon_e.oor));
      chk("busy", 64'(busy), 64'(mon_e.busy));
      chk("flt_ready", 64'(flt_ready), 64'(mon_e.fready));
      chk("cap_err", 64'(cap_err), 64'(mon_e.cap));
    end
  end

  initial begin
    logic [15:0] a;
    int          r;
    rst = 1'b1; memtype = 5'b00011; address = 16'hFFFF; write_read = 1'b0;
    wdata = 64'd0; init_req = 1'b0; flt_load = 1'b0; flt_clear = 1'b0;
    flt_slot = '0; flt_addr = '0; flt_bit = '0; flt_type = '0;
    for (int i = 0; i < NF; i++) ft[i] = '{v: 1'b0, a: 16'd0, b: 0, t: 0};

    repeat (3) drive(1'b0, 16'hFFFF, 64'd0);
    rst = 1'b0;
    wait_ready();
    for (int i = 16'hFE00; i <= 16'hFFFF; i++) drive(1'b0, 16'(i), 64'd0);

    memtype = 5'b00000;
    drive(1'b1, 16'hFE05, '1);
    drive(1'b0, 16'hFE05, 64'd0);
    drive(1'b0, 16'h0005, 64'd0);

    load(0, 16'hFE10, 3, 1);
    load(1, 16'hFE10, 3, 0);
    drive(1'b1, 16'hFE10, 64'd0);
    drive(1'b0, 16'hFE10, 64'd0);

    load(2, 16'hFE20, 0, 2);
    drive(1'b1, 16'hFE20, 64'd0);
    drive(1'b1, 16'hFE20, 64'hFF);
    drive(1'b0, 16'hFE20, 64'd0);

    flt_clear = 1'b1;
    load(0, 16'hFE10, 3, 1);
    drive(1'b0, 16'hFE10, 64'd0);
    load(3, 16'hFE30, 1, 3);
    drive(1'b1, 16'hFE31, 64'hA5);
    init_req = 1'b1;
    drive(1'b0, 16'hFFFF, 64'd0);
    wait_ready();
    for (int i = 16'hFE00; i < 16'hFE40; i++) drive(1'b0, 16'(i), 64'd0);

    memtype = 5'b01011;
    drive(1'b1, 16'hF800, 64'h0123_4567_89AB_CDEF);
    drive(1'b0, 16'hFC00, 64'd0);
    drive(1'b0, 16'hF7FF, 64'd0);

    for (int c = 0; c < 3000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 2) init_req = 1'b1;
      if (r >= 10 && r < 40) memtype = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) begin
        flt_load = 1'b1;
        flt_slot = SW'($urandom_range(0, NF - 1));
        flt_addr = 16'hFFF0 + 16'($urandom_range(0, 7));
        flt_bit  = 6'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 15));
        flt_type = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 199) == 0) flt_clear = 1'b1;
      r = $urandom_range(0, 3);
      if (r < 2) a = 16'hFFF0 + 16'($urandom_range(0, 7));
      else if (r == 2) a = 16'($urandom_range(0, 65535)) | 16'hFE00;
      else a = 16'($urandom_range(0, 65535));
      drive(1'($urandom_range(0, 1)), a, {$urandom, $urandom});
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
